rx_lane_deskew: RTL and testbench
=================================

// Module: rx_lane_deskew
// PURPOSE
//  Per-lane word-granular deskew stage between the per-lane Descrambler outputs and LMC_RX.
//  Finds a common alignment marker on all active lanes and delays early lanes so the marker words line up in the same cycle.
//  Before lock, data passes through with 1-cycle latency, so training ordered sets still reach the decoder.
// PARAMETERS
//  LANES    16  number of lane slots; lane i uses Data[32i+:32], DataK[4i+:4], SyncHeader[2i+:2]
//  MAXSKEW  4   largest tolerated lane-to-lane skew, in clk cycles; delay line depth per lane
// PORTS
//  clk                    in   1     receive clock
//  reset                  in   1     asynchronous, active-low reset
//  GEN                    in   3     current rate (1/2 = 8b10b, 3 = 128b130b)
//  numberOfDetectedLanes  in   5     active lanes; legal values 1,2,4,8,16; active = lanes 0..N-1
//  deskewEnable           in   1     1 = search for / hold lock; 0 = forced bypass
//  inData                 in   512   descrambled data, 32 bits per lane
//  inDataK                in   64    K flags, 1 bit per byte
//  inValid                in   16    per-lane word valid
//  inSyncHeader           in   32    Gen3 sync header per lane
//  deskewData             out  512   aligned data
//  deskewDataK            out  64    aligned K flags
//  deskewValid            out  16    aligned per-lane valid
//  deskewSyncHeader       out  32    aligned sync headers
//  deskewLocked           out  1     1 while in LOCKED
//  deskewError            out  1     1-cycle pulse when skew exceeds MAXSKEW or lock is lost
// BEHAVIOUR
//  Reset (reset=0): state IDLE; all outputs 0; delay lines, arrival regs, and counter cleared.
//  Marker on lane i (only counted when inValid[i]=1):
//   - GEN 1/2: byte0 = 8'hBC and DataK bit0 = 1 (COM).
//   - GEN 3: SyncHeader = 2'b01 and byte0 = 8'hAA (SKP OS).
//  Delay line: one per lane, MAXSKEW+1 entries of {data, K, sh, valid}; shifts every clk.
//  Inactive lanes: deskewData/K/SyncHeader = 0, deskewValid = 0 in every state.
//  FSM:
//   - IDLE: bypass (outputs = inputs registered, 1 cycle). Go to SEARCH when deskewEnable=1.
//   - SEARCH: bypass continues.
//     - First marker on any active lane: skewCnt=0; record arrival_i = skewCnt for every lane with a marker that cycle.
//     - Each later cycle: skewCnt++; record each newly marked lane; repeat markers on already-recorded lanes are ignored.
//     - All active lanes recorded with skewCnt <= MAXSKEW -> LOCKED; delay_i = max(arrival) - arrival_i.
//     - skewCnt reaches MAXSKEW+1 with any lane unrecorded -> pulse deskewError, clear records, stay SEARCH.
//   - LOCKED: lane i output = input delayed 1+delay_i cycles; deskewLocked = 1.
//     - On entry, deskewValid[i] is forced 0 for delay_i cycles; those words are repeats already sent in bypass.
//     - Continuous check on the delayed outputs: a marker on any active lane must appear on all active lanes in the same cycle.
//     - Mismatch -> pulse deskewError, go to SEARCH (bypass) the next cycle.
//  Any state: deskewEnable=0, or a change in GEN or numberOfDetectedLanes -> IDLE next cycle; records cleared; no error pulse.
//  Single active lane: locks on its first marker with delay_0 = 0.
//  Markers on all lanes in the same cycle: all delays = 0.
//  Skew of exactly MAXSKEW locks; MAXSKEW+1 errors.
//  Reset mid-lock: immediate return to reset values.
// TESTING
//  1. x4 Gen1, COM on lanes 0..3 in the same cycle -> LOCKED 1 cycle after; latency 1 on all lanes; no valid gaps.
//  2. x4 Gen1, lane2 COM 3 cycles after lanes 0,1,3 -> delays 3,3,0,3; aligned COM at outputs; lanes 0,1,3 valid gaps of 3 cycles.
//  3. x2 Gen3, SKP on lane1 MAXSKEW+1=5 cycles after lane0 -> deskewError pulse, state SEARCH, deskewLocked = 0.
//  4. Locked x8; inject one lane's marker 1 cycle late -> deskewError pulse, return to SEARCH, relock on next aligned markers.
//  5. Locked x4; drop deskewEnable -> IDLE, 1-cycle bypass, no error; assert reset mid-lock -> all outputs 0 asynchronously.
//  6. x1 with lanes 1..15 toggling data -> lanes 1..15 outputs 0; lane0 locks on first marker with delay 0.

Source files
------------

// File: rtl/rx_lane_deskew.sv
// Word-granular lane deskew: finds a common marker on all active lanes and delays early lanes
// so marker words leave in the same cycle. Before lock, lanes pass through with 1-cycle latency.
module rx_lane_deskew #(
  parameter int LANES   = 16,
  parameter int MAXSKEW = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          GEN,
  input  logic [4:0]          numberOfDetectedLanes,
  input  logic                deskewEnable,
  input  logic [32*LANES-1:0] inData,
  input  logic [4*LANES-1:0]  inDataK,
  input  logic [LANES-1:0]    inValid,
  input  logic [2*LANES-1:0]  inSyncHeader,
  output logic [32*LANES-1:0] deskewData,
  output logic [4*LANES-1:0]  deskewDataK,
  output logic [LANES-1:0]    deskewValid,
  output logic [2*LANES-1:0]  deskewSyncHeader,
  output logic                deskewLocked,
  output logic                deskewError
);
  localparam int DEPTH = MAXSKEW + 1;
  localparam int CW    = $clog2(MAXSKEW + 2);
  localparam logic [CW-1:0] MAXSKEW_C = CW'(MAXSKEW);

  // state  | meaning
  // IDLE   | bypass, waiting for deskewEnable with stable configuration
  // SEARCH | bypass, collecting marker arrival times per active lane
  // LOCKED | each lane delayed by its own offset, marker alignment monitored
  typedef enum logic [1:0] {IDLE, SEARCH, LOCKED} state_t;

  state_t           state_q;
  logic [2:0]       gen_q;
  logic [4:0]       nlanes_q;
  logic [LANES-1:0] active_q;
  logic             started_q;
  logic [CW-1:0]    cnt_q;
  logic [LANES-1:0] rec_q;
  logic [CW-1:0]    arr_q   [LANES];
  logic [CW-1:0]    delay_q [LANES];
  logic [CW-1:0]    gap_q   [LANES];
  logic             err_q;

  logic [31:0] dl_data_q [LANES][DEPTH];
  logic [3:0]  dl_k_q    [LANES][DEPTH];
  logic [1:0]  dl_sh_q   [LANES][DEPTH];
  logic        dl_vld_q  [LANES][DEPTH];

  logic [LANES-1:0] active_d, mark_in, mark_tap, new_mark, rec_d;
  logic [CW-1:0]    cnt_d;
  logic [CW-1:0]    dly_d    [LANES];
  logic [CW-1:0]    sel      [LANES];
  logic [31:0]      tap_data [LANES];
  logic [3:0]       tap_k    [LANES];
  logic [1:0]       tap_sh   [LANES];
  logic             tap_vld  [LANES];
  logic             cfg_change;

  function automatic logic is_marker(input logic [2:0] gen, input logic [7:0] byte0,
                                     input logic k0, input logic [1:0] sh, input logic v);
    if (gen == 3'd3) return v && (sh == 2'b01) && (byte0 == 8'hAA);
    return v && k0 && (byte0 == 8'hBC);
  endfunction

  always_comb begin
    active_d = '0;
    for (int i = 0; i < LANES; i++)
      if (i < int'(numberOfDetectedLanes)) active_d[i] = 1'b1;
  end

  always_comb begin
    mark_in  = '0;
    mark_tap = '0;
    for (int i = 0; i < LANES; i++) begin
      sel[i]      = (state_q == LOCKED) ? delay_q[i] : '0;
      tap_data[i] = dl_data_q[i][sel[i]];
      tap_k[i]    = dl_k_q[i][sel[i]];
      tap_sh[i]   = dl_sh_q[i][sel[i]];
      tap_vld[i]  = dl_vld_q[i][sel[i]];
      mark_in[i]  = active_d[i] & is_marker(GEN, inData[32*i +: 8], inDataK[4*i],
                                             inSyncHeader[2*i +: 2], inValid[i]);
      mark_tap[i] = active_q[i] & is_marker(GEN, tap_data[i][7:0], tap_k[i][0],
                                             tap_sh[i], tap_vld[i]);
    end
  end

  // Arrival times are relative to the first marker; the latest lane gets delay 0.
  always_comb begin
    cnt_d    = started_q ? cnt_q + 1'b1 : '0;
    new_mark = started_q ? (mark_in & ~rec_q) : mark_in;
    rec_d    = (started_q ? rec_q : '0) | mark_in;
    for (int i = 0; i < LANES; i++)
      dly_d[i] = (!active_d[i] || new_mark[i]) ? '0 : cnt_d - arr_q[i];
  end

  assign cfg_change = !deskewEnable || (GEN != gen_q) || (numberOfDetectedLanes != nlanes_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      gen_q     <= '0;
      nlanes_q  <= '0;
      active_q  <= '0;
      started_q <= 1'b0;
      cnt_q     <= '0;
      rec_q     <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        arr_q[i]   <= '0;
        delay_q[i] <= '0;
        gap_q[i]   <= '0;
      end
    end else begin
      gen_q    <= GEN;
      nlanes_q <= numberOfDetectedLanes;
      active_q <= active_d;
      err_q    <= 1'b0;
      if (cfg_change) begin
        state_q   <= IDLE;
        started_q <= 1'b0;
        cnt_q     <= '0;
        rec_q     <= '0;
        for (int i = 0; i < LANES; i++) begin
          delay_q[i] <= '0;
          gap_q[i]   <= '0;
        end
      end else begin
        case (state_q)
          IDLE: state_q <= SEARCH;
          SEARCH: begin
            if (started_q || (|mark_in)) begin
              if (cnt_d > MAXSKEW_C) begin
                err_q     <= 1'b1;
                started_q <= 1'b0;
                cnt_q     <= '0;
                rec_q     <= '0;
              end else if (rec_d == active_d) begin
                state_q   <= LOCKED;
                started_q <= 1'b0;
                cnt_q     <= '0;
                rec_q     <= '0;
                for (int i = 0; i < LANES; i++) begin
                  delay_q[i] <= dly_d[i];
                  gap_q[i]   <= dly_d[i];
                end
              end else begin
                started_q <= 1'b1;
                cnt_q     <= cnt_d;
                rec_q     <= rec_d;
                for (int i = 0; i < LANES; i++)
                  if (new_mark[i]) arr_q[i] <= cnt_d;
              end
            end
          end
          LOCKED: begin
            for (int i = 0; i < LANES; i++)
              if (gap_q[i] != '0) gap_q[i] <= gap_q[i] - 1'b1;
            if ((|mark_tap) && (mark_tap != active_q)) begin
              err_q   <= 1'b1;
              state_q <= SEARCH;
              for (int i = 0; i < LANES; i++) begin
                delay_q[i] <= '0;
                gap_q[i]   <= '0;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LANES; i++)
        for (int j = 0; j < DEPTH; j++) begin
          dl_data_q[i][j] <= '0;
          dl_k_q[i][j]    <= '0;
          dl_sh_q[i][j]   <= '0;
          dl_vld_q[i][j]  <= 1'b0;
        end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        dl_data_q[i][0] <= inData[32*i +: 32];
        dl_k_q[i][0]    <= inDataK[4*i +: 4];
        dl_sh_q[i][0]   <= inSyncHeader[2*i +: 2];
        dl_vld_q[i][0]  <= inValid[i];
        for (int j = 1; j < DEPTH; j++) begin
          dl_data_q[i][j] <= dl_data_q[i][j-1];
          dl_k_q[i][j]    <= dl_k_q[i][j-1];
          dl_sh_q[i][j]   <= dl_sh_q[i][j-1];
          dl_vld_q[i][j]  <= dl_vld_q[i][j-1];
        end
      end
    end
  end

  // Valid is held low while a freshly delayed lane replays words already sent in bypass.
  always_comb begin
    deskewData       = '0;
    deskewDataK      = '0;
    deskewSyncHeader = '0;
    deskewValid      = '0;
    for (int i = 0; i < LANES; i++) begin
      deskewData[32*i +: 32]      = active_q[i] ? tap_data[i] : '0;
      deskewDataK[4*i +: 4]       = active_q[i] ? tap_k[i] : '0;
      deskewSyncHeader[2*i +: 2]  = active_q[i] ? tap_sh[i] : '0;
      deskewValid[i]              = active_q[i] & tap_vld[i] & (gap_q[i] == '0);
    end
  end

  assign deskewLocked = (state_q == LOCKED);
  assign deskewError  = err_q;

endmodule

// File: tb/tb_rx_lane_deskew.sv
// Self-checking bench for rx_lane_deskew: bypass vector table, hand-written error/disable/reset
// sequences, and randomized skewed streams checked against a base-sequence alignment model.
module tb_rx_lane_deskew;
  localparam int LANES   = 16;
  localparam int MAXSKEW = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   GEN;
  logic [4:0]   numberOfDetectedLanes;
  logic         deskewEnable;
  logic [511:0] inData;
  logic [63:0]  inDataK;
  logic [15:0]  inValid;
  logic [31:0]  inSyncHeader;
  logic [511:0] deskewData;
  logic [63:0]  deskewDataK;
  logic [15:0]  deskewValid;
  logic [31:0]  deskewSyncHeader;
  logic         deskewLocked;
  logic         deskewError;

  int total = 0;
  int bad   = 0;

  typedef int off_arr_t [LANES];

  typedef struct {
    logic [4:0]  nl;
    logic [31:0] d0;
    logic [15:0] vld;
    logic [31:0] exp_d0;
    logic [31:0] exp_d1;
    logic [15:0] exp_vld;
  } vec_t;

  rx_lane_deskew #(.LANES(LANES), .MAXSKEW(MAXSKEW)) dut (
    .clk(clk), .reset(reset), .GEN(GEN), .numberOfDetectedLanes(numberOfDetectedLanes),
    .deskewEnable(deskewEnable), .inData(inData), .inDataK(inDataK), .inValid(inValid),
    .inSyncHeader(inSyncHeader), .deskewData(deskewData), .deskewDataK(deskewDataK),
    .deskewValid(deskewValid), .deskewSyncHeader(deskewSyncHeader),
    .deskewLocked(deskewLocked), .deskewError(deskewError)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // word layout {sh[1:0], k[3:0], data[31:0]}
  function automatic logic [37:0] mkword(input logic [2:0] g, input logic [23:0] hi);
    if (g == 3'd3) return {2'b01, 4'h0, hi, 8'hAA};
    return {2'b10, 4'h1, hi, 8'hBC};
  endfunction

  function automatic logic [37:0] fill(input int tag, input int lane);
    return {2'b10, 4'h0, 8'h00, 8'(tag), 8'(lane), 8'h0F};
  endfunction

  // Base sequence: index k carries a marker every 16 words at k%16==8; other words avoid marker bytes.
  function automatic logic [37:0] sword(input int k, input int lane, input logic [2:0] g,
                                        input logic [31:0] seed);
    logic [31:0] h;
    h = (32'(k) * 32'h9E3779B1) ^ (32'(lane) * 32'h85EBCA6B) ^ seed;
    if (k >= 0 && (k % 16) == 8) return mkword(g, h[31:8]);
    return {2'b10, h[3:1], 1'b0, h[31:8], 1'b0, h[6:0]};
  endfunction

  task automatic set_lane(input int i, input logic [37:0] w, input logic v);
    inData[32*i +: 32]      = w[31:0];
    inDataK[4*i +: 4]       = w[35:32];
    inSyncHeader[2*i +: 2]  = w[37:36];
    inValid[i]              = v;
  endtask

  task automatic drive_cycle(input logic [15:0] mk, input logic [2:0] g, input int tag);
    for (int i = 0; i < LANES; i++)
      set_lane(i, mk[i] ? mkword(g, 24'(tag)) : fill(tag, i), 1'b1);
  endtask

  // Leaves the DUT in IDLE with stable config and enable raised; the next edge enters SEARCH.
  task automatic configure(input logic [2:0] g, input int n);
    deskewEnable          = 1'b0;
    GEN                   = g;
    numberOfDetectedLanes = 5'(n);
    drive_cycle('0, g, 0);
    tick();
    tick();
    deskewEnable = 1'b1;
  endtask

  task automatic run_stream(input string name, input int n, input logic [2:0] g,
                            input off_arr_t off, input logic [31:0] seed);
    int maxoff, lc, dly;
    logic [37:0]  w;
    logic [63:0]  r;
    logic [511:0] ed;
    logic [63:0]  ek;
    logic [31:0]  esh;
    logic [15:0]  ev;
    maxoff = 0;
    for (int i = 0; i < n; i++) if (off[i] > maxoff) maxoff = off[i];
    lc = 8 + maxoff;
    configure(g, n);
    for (int c = 0; c < 48; c++) begin
      for (int i = 0; i < LANES; i++) begin
        if (i < n) set_lane(i, sword(c - off[i], i, g, seed), 1'b1);
        else begin
          r = {$urandom, $urandom};
          set_lane(i, r[37:0], r[63]);
        end
      end
      tick();
      ed = '0; ek = '0; esh = '0; ev = '0;
      for (int i = 0; i < n; i++) begin
        dly = maxoff - off[i];
        w = (c < lc) ? sword(c - off[i], i, g, seed) : sword(c - maxoff, i, g, seed);
        ed[32*i +: 32] = w[31:0];
        ek[4*i +: 4]   = w[35:32];
        esh[2*i +: 2]  = w[37:36];
        ev[i]          = (c < lc) || (c >= lc + dly);
      end
      chk($sformatf("%s data c%0d", name, c), deskewData, ed);
      chk($sformatf("%s k c%0d", name, c), deskewDataK, ek);
      chk($sformatf("%s sh c%0d", name, c), deskewSyncHeader, esh);
      chk($sformatf("%s valid c%0d", name, c), deskewValid, ev);
      chk($sformatf("%s locked c%0d", name, c), deskewLocked, c >= lc);
      chk($sformatf("%s err c%0d", name, c), deskewError, 1'b0);
    end
  endtask

  task automatic test_skew_error();
    logic [15:0] mk;
    configure(3'd3, 2);
    for (int c = 0; c < 12; c++) begin
      mk = '0;
      if (c == 2) mk = 16'h0001;
      if (c == 7) mk = 16'h0002;
      drive_cycle(mk, 3'd3, c);
      tick();
      chk($sformatf("skew5 err c%0d", c), deskewError, c == 7);
      chk($sformatf("skew5 locked c%0d", c), deskewLocked, 1'b0);
    end
  endtask

  task automatic test_late_marker();
    logic [15:0] mk;
    configure(3'd1, 8);
    for (int c = 0; c < 16; c++) begin
      mk = '0;
      if (c == 3 || c == 12) mk = 16'h00FF;
      if (c == 8) mk = 16'h007F;
      if (c == 9) mk = 16'h0080;
      drive_cycle(mk, 3'd1, c);
      tick();
      chk($sformatf("late locked c%0d", c), deskewLocked, (c >= 3 && c <= 8) || c >= 12);
      chk($sformatf("late err c%0d", c), deskewError, c == 9);
      chk($sformatf("late lane7 c%0d", c), deskewData[255:224],
          mk[7] ? {8'h00, 8'(c), 8'hBC} : {8'h00, 8'(c), 8'h07, 8'h0F});
    end
  endtask

  function automatic logic [31:0] t5_in(input int x, input int lane);
    logic [37:0] w;
    if ((lane == 2 && x == 5) || (lane != 2 && x == 2)) w = mkword(3'd1, 24'(x));
    else w = fill(x, lane);
    return w[31:0];
  endfunction

  task automatic test_disable_reset();
    logic [15:0] mk;
    logic        lk;
    configure(3'd1, 4);
    for (int c = 0; c < 14; c++) begin
      mk = '0;
      if (c == 2) mk = 16'h000B;
      if (c == 5) mk = 16'h0004;
      if (c == 10) deskewEnable = 1'b0;
      drive_cycle(mk, 3'd1, c);
      tick();
      lk = (c >= 5 && c < 10);
      chk($sformatf("dis locked c%0d", c), deskewLocked, lk);
      chk($sformatf("dis err c%0d", c), deskewError, 1'b0);
      chk($sformatf("dis lane0 c%0d", c), deskewData[31:0], t5_in(lk ? c - 3 : c, 0));
      chk($sformatf("dis lane2 c%0d", c), deskewData[95:64], t5_in(c, 2));
      chk($sformatf("dis valid c%0d", c), deskewValid, (c >= 5 && c <= 7) ? 16'h0004 : 16'h000F);
    end
    deskewEnable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      drive_cycle((c == 2) ? 16'h000F : 16'h0000, 3'd1, c + 40);
      tick();
    end
    chk("relock before reset", deskewLocked, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("rst data", deskewData, '0);
    chk("rst k", deskewDataK, '0);
    chk("rst sh", deskewSyncHeader, '0);
    chk("rst valid", deskewValid, '0);
    chk("rst locked", deskewLocked, 1'b0);
    chk("rst err", deskewError, 1'b0);
    tick();
    reset = 1'b1;
  endtask

  initial begin
    vec_t     vecs [5];
    off_arr_t o;
    vecs[0] = '{5'd16, 32'h1234_5678, 16'hFFFF, 32'h1234_5678, 32'h1234_5679, 16'hFFFF};
    vecs[1] = '{5'd1,  32'hCAFE_0010, 16'hFFFF, 32'hCAFE_0010, 32'h0000_0000, 16'h0001};
    vecs[2] = '{5'd2,  32'h0000_BC01, 16'h00F0, 32'h0000_BC01, 32'h0000_BC00, 16'h0000};
    vecs[3] = '{5'd4,  32'hA5A5_A5A4, 16'h000A, 32'hA5A5_A5A4, 32'hA5A5_A5A5, 16'h000A};
    vecs[4] = '{5'd8,  32'h7E7E_7E70, 16'h5555, 32'h7E7E_7E70, 32'h7E7E_7E71, 16'h0055};

    reset                 = 1'b0;
    deskewEnable          = 1'b0;
    GEN                   = 3'd1;
    numberOfDetectedLanes = 5'd4;
    inData                = {16{32'hDEAD_BEEF}};
    inDataK               = '1;
    inValid               = '1;
    inSyncHeader          = '1;
    tick();
    tick();
    chk("reset data", deskewData, '0);
    chk("reset valid", deskewValid, '0);
    chk("reset locked", deskewLocked, 1'b0);
    chk("reset err", deskewError, 1'b0);
    reset = 1'b1;

    for (int v = 0; v < 5; v++) begin
      numberOfDetectedLanes = vecs[v].nl;
      for (int i = 0; i < LANES; i++)
        set_lane(i, {6'b0, vecs[v].d0 ^ 32'(i)}, vecs[v].vld[i]);
      tick();
      chk($sformatf("vec%0d lane0", v), deskewData[31:0], vecs[v].exp_d0);
      chk($sformatf("vec%0d lane1", v), deskewData[63:32], vecs[v].exp_d1);
      chk($sformatf("vec%0d valid", v), deskewValid, vecs[v].exp_vld);
    end

    o = '{default: 0};
    run_stream("x4 aligned", 4, 3'd1, o, 32'h1111_0000);
    o[2] = 3;
    run_stream("x4 lane2 late", 4, 3'd1, o, 32'h2222_0000);
    o = '{default: 0};
    o[1] = MAXSKEW;
    run_stream("x2 gen3 skew max", 2, 3'd3, o, 32'h3333_0000);
    o = '{default: 0};
    run_stream("x1", 1, 3'd2, o, 32'h4444_0000);

    test_skew_error();
    test_late_marker();
    test_disable_reset();

    for (int r = 0; r < 6; r++) begin
      int n;
      n = 1 << $urandom_range(0, 4);
      for (int i = 0; i < LANES; i++) o[i] = int'($urandom_range(0, MAXSKEW));
      run_stream($sformatf("rand%0d", r), n, 3'($urandom_range(1, 3)), o, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
